jtag_ir_decode_unit: RTL and testbench
======================================

# jtag_ir_decode_unit

Parametrised JTAG instruction-register unit: IR shift/capture stage, instruction update register, and registered one-hot data-register select decode. It sits between the TAP controller (which supplies the capture/shift/update/test-logic-reset strobes) and the data registers (bypass, BSR, IDCODE, AHB, TMP, user channels). It adds a sticky clamp state, illegal-opcode tracking, and a configurable bank of user instructions.

## Interface
Parameters:
- IR_WIDTH, 5: instruction length; must be ≥ 4
- NUM_USER, 4: number of user DR channels; must be ≥ 1
- OP_EXTEST, 5'h00 / OP_IDCODE, 5'h01 / OP_SAMPLE, 5'h02 / OP_PRELOAD, 5'h03 / OP_AHB, 5'h04 / OP_CLAMP_HOLD, 5'h05 / OP_CLAMP_RELEASE, 5'h06 / OP_BYPASS, all ones: fixed opcodes
- OP_USER_BASE, 5'h10: first user opcode; user channel k uses OP_USER_BASE+k

Ports:
- TCK  in  1  test clock; all state updates on the rising edge
- TRST  in  1  reset, synchronous, active-high
- tlr  in  1  TAP is in Test-Logic-Reset
- capture_ir / shift_ir / update_ir  in  1 each  TAP strobes
- tdi  in  1  serial data in
- ir_tdo  out  1  serial out, combinational = sr[0]
- instr  out  IR_WIDTH  current instruction
- bypass_select, bsr_select, bsr_mode, id_select, ahb_select, tmp_select  out  1 each  registered selects
- user_select  out  NUM_USER  one-hot user channel select
- clamp_active  out  1  sticky clamp state
- illegal_seen  out  1  sticky undefined-opcode flag

## Operation
- Shift register sr[IR_WIDTH-1:0]: capture loads {clamp_active, illegal_seen, zeros, 2'b01} (bits 1:0 = 01 per 1149.1); shift does sr <= {tdi, sr[IR_WIDTH-1:1]} (LSB out first).
- Update: instr <= sr; all selects are recomputed from sr and registered on the same edge.
- Decode of the new opcode:
  - BYPASS: bypass_select.
  - SAMPLE / PRELOAD: bsr_select.
  - EXTEST: bsr_select, bsr_mode.
  - IDCODE: id_select.
  - AHB: ahb_select.
  - CLAMP_HOLD: tmp_select; sets clamp_active.
  - CLAMP_RELEASE: tmp_select; clears clamp_active.
  - OP_USER_BASE..OP_USER_BASE+NUM_USER-1: user_select[opcode-OP_USER_BASE].
  - Fixed opcodes take priority over any overlapping user range.
  - Any other value: treated as BYPASS; sets illegal_seen.
- bsr_mode = (instr==EXTEST) OR clamp_active. A held clamp keeps the BSR driving outputs under later instructions until CLAMP_RELEASE.
- Invariant: exactly one of {bypass, bsr, id, ahb, tmp, user[*]} is high at every cycle after reset.
- TRST or tlr:
  - instr = OP_IDCODE; id_select = 1; all other selects 0.
  - clamp_active = 0; illegal_seen = 0.
  - TRST also clears sr to 0; tlr leaves sr unchanged.
- Priority: TRST > tlr > update_ir > capture_ir > shift_ir. The lower strobes are ignored on that edge.

## Timing
- Reset values: instr = OP_IDCODE, id_select = 1, all other selects/flags 0, ir_tdo = 0.
- ir_tdo changes only after capture/shift edges. Shift latency is 1 TCK per bit, so IR_WIDTH shifts fully replace sr.
- Selects, instr, clamp_active and illegal_seen change exactly on the edge where update_ir is sampled high, i.e. 1 cycle after the final shift bit. They are stable otherwise, including during capture/shift; there are no glitches during shifting.
- tlr asserted mid-shift: the decode returns to IDCODE on that edge, and the partial sr content is never applied.
- Update without a prior shift re-applies the current sr. Status bits loaded by capture reflect the flags as of that edge.

## Test plan
- Reset: assert TRST 1 cycle → instr = 5'h01, id_select = 1, clamp_active = 0, ir_tdo = 0; check the one-hot invariant.
- Capture then 5 shifts of tdi = 0,0,0,0,0 then update → instr = 5'h00, bsr_select = 1, bsr_mode = 1. ir_tdo during the shifts shows 1,0,0,0,0 (captured 5'b00001).
- Shift 5'h05 then update → tmp_select = 1, clamp_active = 1. Then load 5'h1F → bypass_select = 1, bsr_mode stays 1. Then load 5'h06 → clamp_active = 0, bsr_mode = 0.
- Load 5'h12 → user_select = 4'b0100. Load 5'h0A → bypass_select = 1, illegal_seen = 1. Next capture shifts out 1,0,0,1,0 (LSB first).
- Assert tlr after 3 shift bits of 5'h04 → id_select = 1, ahb_select never asserts, illegal_seen = 0.
- capture_ir and update_ir asserted on the same edge → update wins. Selects follow the old sr, and sr is not reloaded.

Source files
------------

// File: rtl/jtag_ir_decode_unit.sv
// JTAG instruction-register unit.
// Contains the IR shift/capture stage and the instruction update register.
// Decodes the opcode into registered one-hot data-register selects.
// Also tracks a sticky clamp state and a sticky illegal-opcode flag.
module jtag_ir_decode_unit #(
   parameter int IR_WIDTH = 5,
   parameter int NUM_USER = 4,
   parameter logic [IR_WIDTH-1:0] OP_EXTEST        = IR_WIDTH'(5'h00),
   parameter logic [IR_WIDTH-1:0] OP_IDCODE        = IR_WIDTH'(5'h01),
   parameter logic [IR_WIDTH-1:0] OP_SAMPLE        = IR_WIDTH'(5'h02),
   parameter logic [IR_WIDTH-1:0] OP_PRELOAD       = IR_WIDTH'(5'h03),
   parameter logic [IR_WIDTH-1:0] OP_AHB           = IR_WIDTH'(5'h04),
   parameter logic [IR_WIDTH-1:0] OP_CLAMP_HOLD    = IR_WIDTH'(5'h05),
   parameter logic [IR_WIDTH-1:0] OP_CLAMP_RELEASE = IR_WIDTH'(5'h06),
   parameter logic [IR_WIDTH-1:0] OP_BYPASS        = '1,
   parameter logic [IR_WIDTH-1:0] OP_USER_BASE     = IR_WIDTH'(5'h10)
) (
   input  logic                TCK,
   input  logic                TRST,
   input  logic                tlr,
   input  logic                capture_ir,
   input  logic                shift_ir,
   input  logic                update_ir,
   input  logic                tdi,
   output logic                ir_tdo,
   output logic [IR_WIDTH-1:0] instr,
   output logic                bypass_select,
   output logic                bsr_select,
   output logic                bsr_mode,
   output logic                id_select,
   output logic                ahb_select,
   output logic                tmp_select,
   output logic [NUM_USER-1:0] user_select,
   output logic                clamp_active,
   output logic                illegal_seen
);

   logic [IR_WIDTH-1:0] sr_reg;
   logic [IR_WIDTH-1:0] instr_reg;
   logic [IR_WIDTH-1:0] capture_val;
   logic                bypass_reg, bsr_reg, id_reg, ahb_reg, tmp_reg;
   logic [NUM_USER-1:0] user_reg;
   logic                clamp_reg, illegal_reg;

   logic                bypass_next, bsr_next, id_next, ahb_next, tmp_next;
   logic [NUM_USER-1:0] user_next;
   logic [NUM_USER-1:0] user_hit;
   logic                clamp_next, illegal_next;

   // Each user channel matches its own opcode slot above the base.
   generate
      for (genvar gi = 0; gi < NUM_USER; gi++) begin : g_user_hit
         assign user_hit[gi] = (sr_reg == OP_USER_BASE + IR_WIDTH'(gi));
      end
   endgenerate

   // Capture pattern: status flags in the top two bits, 01 in the bottom two.
   always_comb begin
      capture_val             = '0;
      capture_val[1:0]        = 2'b01;
      capture_val[IR_WIDTH-1] = clamp_reg;
      capture_val[IR_WIDTH-2] = illegal_reg;
   end

   // Decode the shifted opcode; fixed opcodes outrank the user range.
   always_comb begin
      bypass_next  = 1'b0;
      bsr_next     = 1'b0;
      id_next      = 1'b0;
      ahb_next     = 1'b0;
      tmp_next     = 1'b0;
      user_next    = '0;
      clamp_next   = clamp_reg;
      illegal_next = illegal_reg;
      if (sr_reg == OP_BYPASS) begin
         bypass_next = 1'b1;
      end else if (sr_reg == OP_SAMPLE || sr_reg == OP_PRELOAD || sr_reg == OP_EXTEST) begin
         bsr_next = 1'b1;
      end else if (sr_reg == OP_IDCODE) begin
         id_next = 1'b1;
      end else if (sr_reg == OP_AHB) begin
         ahb_next = 1'b1;
      end else if (sr_reg == OP_CLAMP_HOLD) begin
         tmp_next   = 1'b1;
         clamp_next = 1'b1;
      end else if (sr_reg == OP_CLAMP_RELEASE) begin
         tmp_next   = 1'b1;
         clamp_next = 1'b0;
      end else if (|user_hit) begin
         user_next = user_hit;
      end else begin
         // Undefined opcode: behave as BYPASS and remember it happened.
         bypass_next  = 1'b1;
         illegal_next = 1'b1;
      end
   end

   // IR state: reset > test-logic-reset > update > capture > shift.
   always_ff @(posedge TCK) begin
      if (TRST || tlr) begin
         if (TRST) begin
            sr_reg <= '0;
         end
         instr_reg   <= OP_IDCODE;
         bypass_reg  <= 1'b0;
         bsr_reg     <= 1'b0;
         id_reg      <= 1'b1;
         ahb_reg     <= 1'b0;
         tmp_reg     <= 1'b0;
         user_reg    <= '0;
         clamp_reg   <= 1'b0;
         illegal_reg <= 1'b0;
      end else if (update_ir) begin
         instr_reg   <= sr_reg;
         bypass_reg  <= bypass_next;
         bsr_reg     <= bsr_next;
         id_reg      <= id_next;
         ahb_reg     <= ahb_next;
         tmp_reg     <= tmp_next;
         user_reg    <= user_next;
         clamp_reg   <= clamp_next;
         illegal_reg <= illegal_next;
      end else if (capture_ir) begin
         sr_reg <= capture_val;
      end else if (shift_ir) begin
         sr_reg <= {tdi, sr_reg[IR_WIDTH-1:1]};
      end
   end

   assign ir_tdo        = sr_reg[0];
   assign instr         = instr_reg;
   assign bypass_select = bypass_reg;
   assign bsr_select    = bsr_reg;
   assign id_select     = id_reg;
   assign ahb_select    = ahb_reg;
   assign tmp_select    = tmp_reg;
   assign user_select   = user_reg;
   assign clamp_active  = clamp_reg;
   assign illegal_seen  = illegal_reg;
   // A held clamp keeps the boundary register driving pins under any instruction.
   assign bsr_mode      = (instr_reg == OP_EXTEST) || clamp_reg;

endmodule

// File: tb/tb_jtag_ir_decode_unit.sv
// Directed self-checking bench for jtag_ir_decode_unit (default parameters).
module tb_jtag_ir_decode_unit;

   logic       TCK = 1'b0;
   logic       TRST = 1'b0;
   logic       tlr = 1'b0;
   logic       capture_ir = 1'b0;
   logic       shift_ir = 1'b0;
   logic       update_ir = 1'b0;
   logic       tdi = 1'b0;
   logic       ir_tdo;
   logic [4:0] instr;
   logic       bypass_select, bsr_select, bsr_mode, id_select, ahb_select, tmp_select;
   logic [3:0] user_select;
   logic       clamp_active, illegal_seen;

   int checks = 0;
   int errors = 0;

   // Select vector layout: {bypass, bsr, id, ahb, tmp, user[3:0]}
   localparam logic [8:0] SEL_BYP   = 9'h100;
   localparam logic [8:0] SEL_BSR   = 9'h080;
   localparam logic [8:0] SEL_ID    = 9'h040;
   localparam logic [8:0] SEL_TMP   = 9'h010;
   localparam logic [8:0] SEL_USER2 = 9'h004;
   localparam logic [8:0] SEL_USER1 = 9'h002;

   jtag_ir_decode_unit dut (
      .TCK(TCK), .TRST(TRST), .tlr(tlr),
      .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
      .tdi(tdi), .ir_tdo(ir_tdo), .instr(instr),
      .bypass_select(bypass_select), .bsr_select(bsr_select), .bsr_mode(bsr_mode),
      .id_select(id_select), .ahb_select(ahb_select), .tmp_select(tmp_select),
      .user_select(user_select), .clamp_active(clamp_active), .illegal_seen(illegal_seen)
   );

   always #5 TCK = ~TCK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   function automatic logic [8:0] sel_vec();
      return {bypass_select, bsr_select, id_select, ahb_select, tmp_select, user_select};
   endfunction

   task automatic check_sel(input string tag, input logic [8:0] exp);
      check_eq({tag, " sel"}, 32'(sel_vec()), 32'(exp));
      check_eq({tag, " onehot"}, 32'($countones(sel_vec())), 32'd1);
   endtask

   // One TCK cycle with the given strobes; outputs are sampled 1 time unit after the edge.
   task automatic tick(input logic trst_v, input logic tlr_v, input logic upd,
                       input logic cap, input logic sh, input logic d);
      TRST = trst_v; tlr = tlr_v; update_ir = upd; capture_ir = cap; shift_ir = sh; tdi = d;
      @(posedge TCK);
      #1;
      TRST = 0; tlr = 0; update_ir = 0; capture_ir = 0; shift_ir = 0; tdi = 0;
   endtask

   task automatic load_ir(input logic [4:0] v);
      tick(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 1, v[i]);
      tick(0, 0, 1, 0, 0, 0);
   endtask

   // Shift five zeros, checking ir_tdo before each shift edge.
   task automatic shift_out_check(input string tag, input logic [4:0] exp);
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("%s bit%0d", tag, i), 32'(ir_tdo), 32'(exp[i]));
         tick(0, 0, 0, 0, 1, 0);
      end
   endtask

   initial begin
      @(negedge TCK);
      // Reset
      tick(1, 0, 0, 0, 0, 0);
      check_eq("rst instr", 32'(instr), 32'h01);
      check_sel("rst", SEL_ID);
      check_eq("rst clamp", 32'(clamp_active), 32'd0);
      check_eq("rst illegal", 32'(illegal_seen), 32'd0);
      check_eq("rst tdo", 32'(ir_tdo), 32'd0);
      check_eq("rst bsr_mode", 32'(bsr_mode), 32'd0);

      // EXTEST: capture 00001, shift zeros, observe 1,0,0,0,0
      tick(0, 0, 0, 1, 0, 0);
      shift_out_check("cap0", 5'b00001);
      check_eq("shift instr stable", 32'(instr), 32'h01);
      check_sel("shift stable", SEL_ID);
      tick(0, 0, 1, 0, 0, 0);
      check_eq("extest instr", 32'(instr), 32'h00);
      check_sel("extest", SEL_BSR);
      check_eq("extest bsr_mode", 32'(bsr_mode), 32'd1);

      // Clamp hold, bypass under clamp, clamp release
      load_ir(5'h05);
      check_sel("hold", SEL_TMP);
      check_eq("hold clamp", 32'(clamp_active), 32'd1);
      load_ir(5'h1F);
      check_sel("byp clamp", SEL_BYP);
      check_eq("byp bsr_mode", 32'(bsr_mode), 32'd1);
      check_eq("byp illegal", 32'(illegal_seen), 32'd0);
      load_ir(5'h06);
      check_sel("release", SEL_TMP);
      check_eq("release clamp", 32'(clamp_active), 32'd0);
      check_eq("release bsr_mode", 32'(bsr_mode), 32'd0);

      // User channel 2, then illegal opcode
      load_ir(5'h12);
      check_sel("user2", SEL_USER2);
      check_eq("user2 instr", 32'(instr), 32'h12);
      load_ir(5'h0A);
      check_sel("illegal", SEL_BYP);
      check_eq("illegal flag", 32'(illegal_seen), 32'd1);
      tick(0, 0, 0, 1, 0, 0);
      shift_out_check("cap1", 5'b01001);

      // tlr after three bits of AHB (0,0,1): sr = 10001 and stays
      tick(0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 1, 1);
      check_sel("midshift", SEL_BYP);
      tick(0, 1, 0, 0, 0, 0);
      check_eq("tlr instr", 32'(instr), 32'h01);
      check_sel("tlr", SEL_ID);
      check_eq("tlr ahb", 32'(ahb_select), 32'd0);
      check_eq("tlr illegal", 32'(illegal_seen), 32'd0);
      check_eq("tlr sr kept", 32'(ir_tdo), 32'd1);

      // capture + update together: update applies sr 0x11, no reload
      tick(0, 0, 1, 1, 0, 0);
      check_eq("capupd instr", 32'(instr), 32'h11);
      check_sel("capupd", SEL_USER1);
      shift_out_check("capupd sr", 5'b10001);

      // TRST clears clamp and sr
      load_ir(5'h05);
      check_eq("hold2 clamp", 32'(clamp_active), 32'd1);
      tick(0, 0, 0, 1, 0, 0);
      tick(1, 0, 0, 0, 0, 0);
      check_eq("trst clamp", 32'(clamp_active), 32'd0);
      check_eq("trst tdo", 32'(ir_tdo), 32'd0);
      check_sel("trst", SEL_ID);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
